// File: rtl/jt89_bus_if.sv
// jt89_bus_if: CPU write decoder for the SN76489-compatible core.
// Edge-detects byte writes, decodes latch/data bytes into the tone period,
// attenuation and noise control registers, and models the READY wait state
// with a busy counter that advances on the sound clock enable.
module jt89_bus_if #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] noise_ctl,
    output logic       noise_rst,
    output logic       wr_drop
);

    localparam int CW = $clog2(BUSY_CYCLES + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;

    logic          r_wr_act;
    logic          w_wr_act, w_strobe, w_accept;
    logic [1:0]    r_lch;
    logic          r_ltype;
    logic [1:0]    w_ch;
    logic          w_is_vol, w_is_noise;
    logic [9:0]    r_tone [3];
    logic [3:0]    r_vol  [4];
    logic [2:0]    r_noise;
    logic          r_noise_rst, r_wr_drop;

    assign w_wr_act = !cs_n && !wr_n;
    assign w_strobe = w_wr_act && !r_wr_act;
    assign ready    = (r_state == S_IDLE);
    // Acceptance looks at the state before the edge, so a strobe landing on
    // the BUSY->IDLE edge is still dropped.
    assign w_accept = w_strobe && ready;

    // Latch bytes carry their own target; data bytes reuse the latched one.
    assign w_ch       = din[7] ? din[6:5] : r_lch;
    assign w_is_vol   = din[7] ? din[4]   : r_ltype;
    assign w_is_noise = !w_is_vol && (w_ch == 2'd3);

    // Registered copy of bus activity for rising-edge strobe detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_act <= 1'b0;
        else        r_wr_act <= w_wr_act;
    end

    // Busy FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Busy FSM next state: load on accept, count down on clken, release at 1.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_BUSY;
                    w_cnt_nx   = CW'(BUSY_CYCLES);
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_IDLE;
                end else if (clken) begin
                    w_cnt_nx = r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Register file update from accepted latch/data bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lch   <= 2'd0;
            r_ltype <= 1'b0;
            r_noise <= 3'd0;
            for (int i = 0; i < 3; i++) r_tone[i] <= 10'd0;
            for (int i = 0; i < 4; i++) r_vol[i]  <= 4'hF;
        end else if (w_accept) begin
            if (din[7]) begin
                r_lch   <= din[6:5];
                r_ltype <= din[4];
            end
            if (w_is_vol) begin
                for (int i = 0; i < 4; i++)
                    if (w_ch == 2'(i)) r_vol[i] <= din[3:0];
            end else if (w_is_noise) begin
                r_noise <= din[2:0];
            end else begin
                for (int i = 0; i < 3; i++)
                    if (w_ch == 2'(i)) begin
                        if (din[7]) r_tone[i][3:0] <= din[3:0];
                        else        r_tone[i][9:4] <= din[5:0];
                    end
            end
        end
    end

    // Single-cycle pulses: LFSR clear on noise writes, drop on busy strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_noise_rst <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_noise_rst <= w_accept && w_is_noise;
            r_wr_drop   <= w_strobe && !ready;
        end
    end

    assign tone0     = r_tone[0];
    assign tone1     = r_tone[1];
    assign tone2     = r_tone[2];
    assign vol0      = r_vol[0];
    assign vol1      = r_vol[1];
    assign vol2      = r_vol[2];
    assign vol3      = r_vol[3];
    assign noise_ctl = r_noise;
    assign noise_rst = r_noise_rst;
    assign wr_drop   = r_wr_drop;

endmodule

// File: doc/jt89_bus_if.md
Name: jt89_bus_if

Overview:
- CPU-side write decoder for the SN76489-compatible core.
- Accepts byte writes on the chip's 8-bit bus and decodes latch/data bytes into the tone-period, attenuation and noise-control registers that drive the tone and noise generators.
- Emulates the chip's READY wait-state behaviour with a busy counter running on the sound clock enable.
- This block is the producer side of the tone-period and attenuation buses the tone channels consume.

Parameters:
- BUSY_CYCLES, 32, number of clken-qualified cycles READY is held low after an accepted write (1..255).

Ports:
- clk        in   1   system clock
- rst_n      in   1   asynchronous active-low reset
- clken      in   1   sound clock enable; the busy counter advances only when high
- cs_n       in   1   chip select, active low
- wr_n       in   1   write strobe, active low
- din        in   8   CPU data byte
- ready      out  1   high = able to accept a write; low = busy
- tone0      out  10  channel 0 tone period
- tone1      out  10  channel 1 tone period
- tone2      out  10  channel 2 tone period
- vol0       out  4   channel 0 attenuation (0 = loudest, 15 = off)
- vol1       out  4   channel 1 attenuation
- vol2       out  4   channel 2 attenuation
- vol3       out  4   noise channel attenuation
- noise_ctl  out  3   noise control: [2] white/periodic, [1:0] shift-rate select
- noise_rst  out  1   one-clk pulse; clears the noise LFSR on any noise_ctl write
- wr_drop    out  1   one-clk pulse; a write strobe arrived while busy and was discarded

Behaviour:
- Reset (rst_n low, asynchronous):
  - tone0..2 = 0; vol0..3 = 4'hF; noise_ctl = 0
  - latch register = channel 0, tone type
  - ready = 1; busy counter = 0; noise_rst = 0; wr_drop = 0
- Write detect:
  - wr_act = !cs_n & !wr_n, registered each clk.
  - A strobe is the cycle in which wr_act = 1 and its registered copy = 0 (rising edge of activity).
  - Holding the strobe low never produces a second write.
- Acceptance:
  - A strobe with ready = 1 is accepted.
  - A strobe with ready = 0 is discarded, and wr_drop pulses for 1 clk on the next edge.
- Decode of an accepted byte; all register updates are visible on the clk edge after the strobe cycle (latency 1):
  - din[7] = 1 (latch byte):
    - latch channel <= din[6:5]; latch type <= din[4] (1 = volume, 0 = tone/noise).
    - Volume type: vol[ch] <= din[3:0].
    - Tone type, ch 0..2: tone[ch][3:0] <= din[3:0]; bits [9:4] unchanged.
    - Tone type, ch 3: noise_ctl <= din[2:0]; noise_rst pulses.
  - din[7] = 0 (data byte), acting on the latched channel/type; the latch is unchanged:
    - Volume type: vol[ch] <= din[3:0].
    - Tone type, ch 0..2: tone[ch][9:4] <= din[5:0]; bits [3:0] unchanged.
    - Tone type, ch 3: noise_ctl <= din[2:0]; noise_rst pulses.
- noise_rst:
  - Exactly 1 clk wide, coincident with the noise_ctl update.
  - It pulses even if the value written is unchanged.
- Busy FSM, two states:
  - IDLE (ready = 1): an accepted write loads the counter with BUSY_CYCLES and moves to BUSY. ready is 0 from the same edge that updates the registers.
  - BUSY (ready = 0): the counter decrements on clk edges with clken = 1. When the counter is 1 and clken = 1, it goes to 0 and the FSM returns to IDLE (ready = 1).
  - clken held low freezes BUSY indefinitely.
  - The counter is sized to hold BUSY_CYCLES; there is no wrap-around because the decrement stops at 0.
- A strobe in the same cycle that BUSY returns to IDLE is discarded; acceptance uses the ready value before the edge.
- Reset asserted mid-BUSY or mid-write: everything returns to reset values immediately, and a pending strobe is lost.
  - After rst_n deasserts with wr_act already 1, the registered copy is 0 from reset, so one strobe is recognised.

Test Plan:
- Reset -> all tones 0, vols 15, noise_ctl 0, ready 1. Then write 0x8E, wait for ready, write 0x0F -> tone0 = 10'h0FE; ready low for exactly 32 clken cycles after each write.
- Write 0xBA -> vol1 = 4'hA, latch unchanged for tones. Then write 0x05 -> vol1 = 4'h5, tone1 untouched.
- Write 0xE5 -> noise_ctl = 3'b101 and a single 1-clk noise_rst. Then data byte 0x03 -> noise_ctl = 3'b011 and a second noise_rst.
- Write 0x81, then a second strobe 10 clken cycles later (0x90) -> second write discarded: wr_drop pulses once, vol0 stays 15, ready timing unaffected.
- Hold cs_n = wr_n = 0 for 100 clk with din = 0x9C -> exactly one write: vol0 = 12, one busy period, no wr_drop.
- Assert rst_n low midway through BUSY with clken toggling -> ready = 1 and registers at reset values asynchronously, before the next clk edge.
